// File: rtl/ddr_mch_burst_ctrl.sv
// Round-robin DDR burst arbiter and per-channel frame address generator for CH_NUM write and CH_NUM read streams.
// Latency: request/address/channel are registered one cycle after the grant decision; at least one IDLE cycle between bursts.
// Backpressure: a request holds ddr_addr/ddr_ch stable until its matching finish pulse; channels wait on FIFO fill levels.
module ddr_mch_burst_ctrl #(
  parameter int CH_NUM  = 2,
  parameter int ADDR_W  = 25,
  parameter int LEN_W   = 10,
  parameter int USE_W   = 10,
  parameter int WRAP_EN = 0,
  localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     clk_ref,
  input  logic                     rst,
  input  logic                     ddr_init_done,
  input  logic [LEN_W-1:0]         wr_length,
  input  logic [LEN_W-1:0]         rd_length,
  input  logic [CH_NUM*ADDR_W-1:0] wr_base,
  input  logic [CH_NUM*ADDR_W-1:0] wr_max,
  input  logic [CH_NUM*ADDR_W-1:0] rd_base,
  input  logic [CH_NUM*ADDR_W-1:0] rd_max,
  input  logic [CH_NUM-1:0]        wr_load,
  input  logic [CH_NUM-1:0]        rd_load,
  input  logic [CH_NUM*USE_W-1:0]  wrf_use,
  input  logic [CH_NUM*USE_W-1:0]  rdf_use,
  input  logic [CH_NUM-1:0]        rd_enable,
  output logic                     ddr_wr_req,
  output logic                     ddr_rd_req,
  output logic [ADDR_W-1:0]        ddr_addr,
  output logic [CH_W-1:0]          ddr_ch,
  input  logic                     ddr_wr_finish,
  input  logic                     ddr_rd_finish,
  output logic [CH_NUM-1:0]        frame_write_done,
  output logic [CH_NUM-1:0]        frame_read_done
);

  localparam int CMP_W = (USE_W > LEN_W) ? USE_W : LEN_W;

  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   wr_ptr [CH_NUM];
  logic [ADDR_W-1:0]   rd_ptr [CH_NUM];
  logic [ADDR_W:0]     wr_sum [CH_NUM];
  logic [ADDR_W:0]     rd_sum [CH_NUM];
  logic [CH_NUM-1:0]   wr_fit, rd_fit;
  logic [CH_NUM-1:0]   wr_load_q, rd_load_q, wr_rise, rd_rise;
  logic [CH_NUM-1:0]   wr_elig, rd_elig;
  logic [CH_W-1:0]     wr_rr, rd_rr, wr_pick, rd_pick;
  logic                grant_wr, grant_rd, fin_wr, fin_rd;

  // First eligible channel searching upward from rr+1, wrapping modulo CH_NUM.
  function automatic logic [CH_W-1:0] rr_pick(input logic [CH_NUM-1:0] elig,
                                              input logic [CH_W-1:0]   rr);
    logic [CH_W-1:0] pick;
    logic [CH_W-1:0] idx;
    pick = rr;
    for (int k = CH_NUM; k >= 1; k--) begin
      idx = CH_W'((int'(rr) + k) % CH_NUM);
      if (elig[idx]) pick = idx;
    end
    return pick;
  endfunction

  // Eligibility, load edges and end-of-frame arithmetic (one extra bit so the sum never wraps).
  always_comb begin
    wr_rise = wr_load & ~wr_load_q;
    rd_rise = rd_load & ~rd_load_q;
    for (int i = 0; i < CH_NUM; i++) begin
      wr_elig[i] = (CMP_W'(wrf_use[i*USE_W +: USE_W]) >= CMP_W'(wr_length)) &&
                   ((WRAP_EN != 0) || !frame_write_done[i]);
      rd_elig[i] = rd_enable[i] &&
                   (CMP_W'(rdf_use[i*USE_W +: USE_W]) < CMP_W'(rd_length)) &&
                   ((WRAP_EN != 0) || !frame_read_done[i]);
      wr_sum[i]  = {1'b0, wr_ptr[i]} + (ADDR_W+1)'(wr_length);
      rd_sum[i]  = {1'b0, rd_ptr[i]} + (ADDR_W+1)'(rd_length);
      wr_fit[i]  = wr_sum[i] < {1'b0, wr_max[i*ADDR_W +: ADDR_W]};
      rd_fit[i]  = rd_sum[i] < {1'b0, rd_max[i*ADDR_W +: ADDR_W]};
    end
    wr_pick = rr_pick(wr_elig, wr_rr);
    rd_pick = rr_pick(rd_elig, rd_rr);
  end

  // FSM state register.
  always_ff @(posedge clk_ref) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: writes win over reads in IDLE; bursts end only on their own finish pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ddr_init_done && (|wr_elig))      state_nxt = WR;
        else if (ddr_init_done && (|rd_elig)) state_nxt = RD;
      end
      WR:      if (ddr_wr_finish) state_nxt = IDLE;
      RD:      if (ddr_rd_finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM decode: grant and finish strobes that drive the registered datapath.
  always_comb begin
    grant_wr = (state == IDLE) && ddr_init_done && (|wr_elig);
    grant_rd = (state == IDLE) && ddr_init_done && !(|wr_elig) && (|rd_elig);
    fin_wr   = (state == WR) && ddr_wr_finish;
    fin_rd   = (state == RD) && ddr_rd_finish;
  end

  // Registered request, address, channel and round-robin pointers.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      ddr_wr_req <= 1'b0;
      ddr_rd_req <= 1'b0;
      ddr_addr   <= '0;
      ddr_ch     <= '0;
      wr_rr      <= CH_W'(CH_NUM - 1);
      rd_rr      <= CH_W'(CH_NUM - 1);
    end else begin
      if (grant_wr) begin
        ddr_wr_req <= 1'b1;
        ddr_ch     <= wr_pick;
        ddr_addr   <= wr_ptr[wr_pick];
        wr_rr      <= wr_pick;
      end else if (grant_rd) begin
        ddr_rd_req <= 1'b1;
        ddr_ch     <= rd_pick;
        ddr_addr   <= rd_ptr[rd_pick];
        rd_rr      <= rd_pick;
      end
      if (fin_wr) ddr_wr_req <= 1'b0;
      if (fin_rd) ddr_rd_req <= 1'b0;
    end
  end

  // Per-channel frame pointers: read-disable beats load, load beats the finish update.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      wr_load_q        <= '0;
      rd_load_q        <= '0;
      frame_write_done <= '0;
      frame_read_done  <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      wr_load_q <= wr_load;
      rd_load_q <= rd_load;
      for (int i = 0; i < CH_NUM; i++) begin
        if (wr_rise[i]) begin
          wr_ptr[i]           <= wr_base[i*ADDR_W +: ADDR_W];
          frame_write_done[i] <= 1'b0;
        end else if (fin_wr && (ddr_ch == CH_W'(i))) begin
          if (wr_fit[i]) begin
            wr_ptr[i] <= wr_sum[i][ADDR_W-1:0];
          end else begin
            frame_write_done[i] <= 1'b1;
            if (WRAP_EN != 0) wr_ptr[i] <= wr_base[i*ADDR_W +: ADDR_W];
          end
        end else if (WRAP_EN != 0) begin
          frame_write_done[i] <= 1'b0;
        end

        if (!rd_enable[i]) begin
          rd_ptr[i]          <= rd_base[i*ADDR_W +: ADDR_W];
          frame_read_done[i] <= 1'b0;
        end else if (rd_rise[i]) begin
          rd_ptr[i]          <= rd_base[i*ADDR_W +: ADDR_W];
          frame_read_done[i] <= 1'b0;
        end else if (fin_rd && (ddr_ch == CH_W'(i))) begin
          if (rd_fit[i]) begin
            rd_ptr[i] <= rd_sum[i][ADDR_W-1:0];
          end else begin
            frame_read_done[i] <= 1'b1;
            if (WRAP_EN != 0) rd_ptr[i] <= rd_base[i*ADDR_W +: ADDR_W];
          end
        end else if (WRAP_EN != 0) begin
          frame_read_done[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_mch_burst_ctrl.sv
// Randomized bench for ddr_mch_burst_ctrl: stop-at-end and wrap-around instances share stimulus.
// Each instance is tracked by a frame/burst reference model; outputs compared every cycle on the falling edge.
// Finish pulses are random and may be mismatched or arrive in IDLE, exercising the ignore rules.
module tb_ddr_mch_burst_ctrl;
  localparam int CH = 2;
  localparam int AW = 25;
  localparam int LW = 10;
  localparam int UW = 10;
  localparam int NCYC = 3000;

  logic clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  logic             rst, ddr_init_done;
  logic [LW-1:0]    wr_length, rd_length;
  logic [CH*AW-1:0] wr_base, wr_max, rd_base, rd_max;
  logic [CH-1:0]    wr_load, rd_load, rd_enable;
  logic [CH*UW-1:0] wrf_use, rdf_use;
  logic             ddr_wr_finish, ddr_rd_finish;

  logic             o_wr_req [2];
  logic             o_rd_req [2];
  logic [AW-1:0]    o_addr   [2];
  logic [0:0]       o_ch     [2];
  logic [CH-1:0]    o_fwd    [2];
  logic [CH-1:0]    o_frd    [2];

  ddr_mch_burst_ctrl #(.CH_NUM(CH), .ADDR_W(AW), .LEN_W(LW), .USE_W(UW), .WRAP_EN(0)) u_dut_stop (
    .clk_ref(clk_ref), .rst(rst), .ddr_init_done(ddr_init_done),
    .wr_length(wr_length), .rd_length(rd_length),
    .wr_base(wr_base), .wr_max(wr_max), .rd_base(rd_base), .rd_max(rd_max),
    .wr_load(wr_load), .rd_load(rd_load), .wrf_use(wrf_use), .rdf_use(rdf_use),
    .rd_enable(rd_enable), .ddr_wr_req(o_wr_req[0]), .ddr_rd_req(o_rd_req[0]),
    .ddr_addr(o_addr[0]), .ddr_ch(o_ch[0]),
    .ddr_wr_finish(ddr_wr_finish), .ddr_rd_finish(ddr_rd_finish),
    .frame_write_done(o_fwd[0]), .frame_read_done(o_frd[0])
  );

  ddr_mch_burst_ctrl #(.CH_NUM(CH), .ADDR_W(AW), .LEN_W(LW), .USE_W(UW), .WRAP_EN(1)) u_dut_wrap (
    .clk_ref(clk_ref), .rst(rst), .ddr_init_done(ddr_init_done),
    .wr_length(wr_length), .rd_length(rd_length),
    .wr_base(wr_base), .wr_max(wr_max), .rd_base(rd_base), .rd_max(rd_max),
    .wr_load(wr_load), .rd_load(rd_load), .wrf_use(wrf_use), .rdf_use(rdf_use),
    .rd_enable(rd_enable), .ddr_wr_req(o_wr_req[1]), .ddr_rd_req(o_rd_req[1]),
    .ddr_addr(o_addr[1]), .ddr_ch(o_ch[1]),
    .ddr_wr_finish(ddr_wr_finish), .ddr_rd_finish(ddr_rd_finish),
    .frame_write_done(o_fwd[1]), .frame_read_done(o_frd[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state per instance (index 0 = stop at frame end, 1 = wrap).
  int m_busy [2];               // 0 idle, 1 write burst, 2 read burst
  bit m_wreq [2];
  bit m_rreq [2];
  int m_addr [2];
  int m_ch   [2];
  int m_wlast[2];
  int m_rlast[2];
  int m_wptr [2][CH];
  int m_rptr [2][CH];
  bit m_wdone[2][CH];
  bit m_rdone[2][CH];
  bit m_wl_prev[CH];
  bit m_rl_prev[CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Next channel after the last winner that wants service; -1 when nobody does.
  function automatic int next_after(input bit want[CH], input int last);
    for (int k = 1; k <= CH; k++) begin
      if (want[(last + k) % CH]) return (last + k) % CH;
    end
    return -1;
  endfunction

  // Advance instance w across one rising edge using the inputs now on the pins.
  task automatic model_step(input int w);
    bit wrap;
    bit wwant[CH];
    bit rwant[CH];
    bit wfin, rfin;
    int fch, c, base, lim, nxt;
    wrap = (w == 1);
    if (rst) begin
      m_busy[w] = 0; m_wreq[w] = 0; m_rreq[w] = 0; m_addr[w] = 0; m_ch[w] = 0;
      m_wlast[w] = CH - 1; m_rlast[w] = CH - 1;
      for (int i = 0; i < CH; i++) begin
        m_wptr[w][i] = 0; m_rptr[w][i] = 0; m_wdone[w][i] = 0; m_rdone[w][i] = 0;
      end
      return;
    end
    for (int i = 0; i < CH; i++) begin
      wwant[i] = (int'(wrf_use[i*UW +: UW]) >= int'(wr_length)) && (wrap || !m_wdone[w][i]);
      rwant[i] = rd_enable[i] && (int'(rdf_use[i*UW +: UW]) < int'(rd_length)) &&
                 (wrap || !m_rdone[w][i]);
    end
    wfin = (m_busy[w] == 1) && ddr_wr_finish;
    rfin = (m_busy[w] == 2) && ddr_rd_finish;
    fch  = m_ch[w];

    if (m_busy[w] == 0 && ddr_init_done) begin
      c = next_after(wwant, m_wlast[w]);
      if (c >= 0) begin
        m_wreq[w] = 1; m_ch[w] = c; m_addr[w] = m_wptr[w][c]; m_wlast[w] = c; m_busy[w] = 1;
      end else begin
        c = next_after(rwant, m_rlast[w]);
        if (c >= 0) begin
          m_rreq[w] = 1; m_ch[w] = c; m_addr[w] = m_rptr[w][c]; m_rlast[w] = c; m_busy[w] = 2;
        end
      end
    end
    if (wfin) begin m_wreq[w] = 0; m_busy[w] = 0; end
    if (rfin) begin m_rreq[w] = 0; m_busy[w] = 0; end

    for (int i = 0; i < CH; i++) begin
      base = int'(wr_base[i*AW +: AW]);
      lim  = int'(wr_max[i*AW +: AW]);
      if (wr_load[i] && !m_wl_prev[i]) begin
        m_wptr[w][i] = base; m_wdone[w][i] = 0;
      end else if (wfin && fch == i) begin
        nxt = m_wptr[w][i] + int'(wr_length);
        if (nxt < lim) m_wptr[w][i] = nxt;
        else begin m_wdone[w][i] = 1; if (wrap) m_wptr[w][i] = base; end
      end else if (wrap) m_wdone[w][i] = 0;

      base = int'(rd_base[i*AW +: AW]);
      lim  = int'(rd_max[i*AW +: AW]);
      if (!rd_enable[i] || (rd_load[i] && !m_rl_prev[i])) begin
        m_rptr[w][i] = base; m_rdone[w][i] = 0;
      end else if (rfin && fch == i) begin
        nxt = m_rptr[w][i] + int'(rd_length);
        if (nxt < lim) m_rptr[w][i] = nxt;
        else begin m_rdone[w][i] = 1; if (wrap) m_rptr[w][i] = base; end
      end else if (wrap) m_rdone[w][i] = 0;
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] fw, fr;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < CH; i++) begin
        fw[i] = m_wdone[w][i];
        fr[i] = m_rdone[w][i];
      end
      check_val($sformatf("i%0d wr_req", w), 32'(o_wr_req[w]), 32'(m_wreq[w]));
      check_val($sformatf("i%0d rd_req", w), 32'(o_rd_req[w]), 32'(m_rreq[w]));
      check_val($sformatf("i%0d addr", w), 32'(o_addr[w]), 32'(m_addr[w]));
      check_val($sformatf("i%0d ch", w), 32'(o_ch[w]), 32'(m_ch[w]));
      check_val($sformatf("i%0d frame_write_done", w), 32'(o_fwd[w]), 32'(fw));
      check_val($sformatf("i%0d frame_read_done", w), 32'(o_frd[w]), 32'(fr));
    end
  endtask

  task automatic new_frame_cfg();
    int b;
    for (int i = 0; i < CH; i++) begin
      b = $urandom_range(0, 64);
      wr_base[i*AW +: AW] = AW'(b);
      wr_max[i*AW +: AW]  = AW'(b + $urandom_range(0, 80));
      b = $urandom_range(0, 64);
      rd_base[i*AW +: AW] = AW'(b);
      rd_max[i*AW +: AW]  = AW'(b + $urandom_range(0, 80));
    end
  endtask

  task automatic drive_random();
    rst           = (cyc < 3) || (cyc == 1500) || (cyc == 1501);
    ddr_init_done = ($urandom_range(0, 9) != 0);
    if ($urandom_range(0, 19) == 0) wr_length = LW'($urandom_range(1, 16));
    if ($urandom_range(0, 19) == 0) rd_length = LW'($urandom_range(1, 16));
    if ($urandom_range(0, 49) == 0) new_frame_cfg();
    for (int i = 0; i < CH; i++) begin
      if ($urandom_range(0, 19) == 0) wr_load[i] = ~wr_load[i];
      if ($urandom_range(0, 19) == 0) rd_load[i] = ~rd_load[i];
      if ($urandom_range(0, 29) == 0) rd_enable[i] = ~rd_enable[i];
      wrf_use[i*UW +: UW] = UW'($urandom_range(0, 20));
      rdf_use[i*UW +: UW] = UW'($urandom_range(0, 20));
    end
    ddr_wr_finish = ($urandom_range(0, 9) < 3);
    ddr_rd_finish = ($urandom_range(0, 9) < 3);
  endtask

  initial begin
    wr_length = 10'd8; rd_length = 10'd8;
    wr_load = '0; rd_load = '0; rd_enable = '1;
    wr_base = '0; wr_max = '0; rd_base = '0; rd_max = '0;
    new_frame_cfg();
    for (cyc = 0; cyc < NCYC; cyc++) begin
      drive_random();
      model_step(0);
      model_step(1);
      for (int i = 0; i < CH; i++) begin
        m_wl_prev[i] = rst ? 1'b0 : wr_load[i];
        m_rl_prev[i] = rst ? 1'b0 : rd_load[i];
      end
      @(negedge clk_ref);
      compare_all();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
